// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider.
// Handshake: start is accepted only while the unit is idle (busy=0, done=0); operands are captured on that edge,
// busy stays high until completion, and done pulses for exactly one cycle with results that then hold until the next done.
interface seq_divider_if #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
);
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, div_zero, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, div_zero, busy, done
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, DVD_W iterations,
// with a short path for a zero divisor.
module seq_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus,
  output logic [1:0]    o_dbg_state
);
  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DVD_W-1:0]   r_dvd;   // holds dividend bits, quotient bits shift in at the LSB
  logic [DVS_W-1:0]   r_dvs;
  logic [DVS_W-1:0]   r_rem;
  logic [DVD_W-1:0]   r_quot;
  logic [DVS_W-1:0]   r_remd;
  logic               r_dz;

  logic [DVS_W:0]     w_shift;
  logic               w_ge;
  logic [DVS_W-1:0]   w_diff;
  logic [DVS_W-1:0]   w_rem_next;
  logic [DVD_W-1:0]   w_q_next;
  logic               w_last;

  // The shifted partial remainder is one bit wider than the divisor so its MSB survives the compare.
  assign w_shift    = {r_rem, r_dvd[DVD_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[DVS_W-1:0] - r_dvs;
  assign w_rem_next = w_ge ? w_diff : w_shift[DVS_W-1:0];
  assign w_q_next   = {r_dvd[DVD_W-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(DVD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next_state = (bus.divisor == '0) ? S_ZERO : S_RUN;
      S_RUN:  if (w_last)    w_next_state = S_DONE;
      S_ZERO: w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state == S_RUN) || (r_state == S_ZERO);
    bus.done    = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd <= bus.dividend;
            r_dvs <= bus.divisor;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot <= w_q_next;
            r_remd <= w_rem_next;
            r_dz   <= 1'b0;
          end
        end
        S_ZERO: begin
          r_quot <= '1;
          r_remd <= '0;
          r_dz   <= 1'b1;
        end
        S_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remd;
  assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotient/remainder vectors,
// latency, ignored starts, held start and reset abort.
module tb_seq_divider;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_miss;

  seq_divider_if #(.DVD_W(16), .DVS_W(8)) bus ();

  seq_divider #(.DVD_W(16), .DVS_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns just after the accepting edge k.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Counts edges after k until done rises; 41 means it never rose within the budget.
  task automatic wait_done(output int lat);
    lat = 41;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int j = 0; j < cycles; j++) begin
      tick();
      if (bus.done !== 1'b0) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [15:0] exp_q, input logic [7:0] exp_r, input logic exp_dz,
                        input int exp_lat);
    int lat;
    start_op(dvd, dvs);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"}, 32'(bus.quotient), 32'(exp_q));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(exp_r));
    chk({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    chk({tag, "_q_hold"}, 32'(bus.quotient), 32'(exp_q));
    chk({tag, "_r_hold"}, 32'(bus.remainder), 32'(exp_r));
  endtask

  // Done rises 16 edges after the accepting edge (sampled high on edge k+17); zero divisor after 1 (edge k+2).
  localparam int LAT_RUN  = 16;
  localparam int LAT_ZERO = 1;

  initial begin
    int lat;
    n_vec        = 0;
    n_miss       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    no_done_for("rst_idle_no_done", 20);

    // basic vectors
    run_op("d200_7", 16'd200, 8'd7, 16'd28, 8'd4, 1'b0, LAT_RUN);
    run_op("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, LAT_RUN);
    run_op("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, LAT_RUN);
    run_op("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, LAT_RUN);
    run_op("d0_13", 16'd0, 8'd13, 16'd0, 8'd0, 1'b0, LAT_RUN);
    run_op("d1000_3", 16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, LAT_RUN);

    // divide by zero, then a normal op clears div_zero
    run_op("d1234_0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, LAT_ZERO);
    run_op("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, LAT_RUN);

    // start during RUN is ignored; operand changes after capture have no effect
    start_op(16'd200, 8'd7);
    for (int j = 1; j <= 4; j++) tick();
    bus.dividend = 16'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 16'd1;
    bus.divisor  = 8'd3;
    chk("ign_busy", 32'(bus.busy), 32'd1);
    lat = 41;
    for (int j = 6; j <= 40; j++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = j;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'(LAT_RUN));
    chk("ign_q", 32'(bus.quotient), 32'd28);
    chk("ign_r", 32'(bus.remainder), 32'd4);
    no_done_for("ign_single_done", 25);

    // start held high through DONE launches the next op from IDLE
    bus.dividend = 16'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    wait_done(lat);
    chk("held1_lat", 32'(lat), 32'(LAT_RUN));
    chk("held1_q", 32'(bus.quotient), 32'd28);
    bus.dividend = 16'd81;
    bus.divisor  = 8'd9;
    tick();
    chk("held_idle_busy", 32'(bus.busy), 32'd0);
    chk("held_idle_state", 32'(dbg_state), 32'd0);
    tick();
    bus.start = 1'b0;
    chk("held2_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("held2_lat", 32'(lat), 32'(LAT_RUN));
    chk("held2_q", 32'(bus.quotient), 32'd9);
    chk("held2_r", 32'(bus.remainder), 32'd0);
    tick();

    // reset mid-operation aborts without a done
    run_op("pre_abort", 16'd77, 8'd10, 16'd7, 8'd7, 1'b0, LAT_RUN);
    start_op(16'd200, 8'd7);
    for (int j = 1; j <= 7; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    chk("abort_dz", 32'(bus.div_zero), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    no_done_for("abort_no_done", 25);
    run_op("d81_9", 16'd81, 8'd9, 16'd9, 8'd0, 1'b0, LAT_RUN);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
